// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned DefDataBits  = 8;
    localparam int unsigned DefSmpPerBit = 9;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StStop   = 3'd3
`ifdef UART_RX_PARITY_EN
        ,
        StParity = 3'd4
`endif
    } rx_state_e;

    // Sample index of vote k (0..2): centred on the middle tick of the bit.
    function automatic int unsigned vote_idx(input int unsigned smp_per_bit,
                                             input int unsigned k);
        return smp_per_bit / 2 - 1 + k;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Received-word handshake and error pulses between the UART receiver and its consumer.
interface uart_rx_ctrl_if #(
    parameter int unsigned DATA_BITS = uart_pkg::DefDataBits
) ();

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus falling-edge detect on the synchronised value.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rxd,
    output logic rxd_s,
    output logic fall
);

    logic meta_q, sync_q, dly_q;

    // All flops reset to the idle line level so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            dly_q  <= 1'b1;
        end else begin
            meta_q <= rxd;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign rxd_s = sync_q;
    assign fall  = dly_q & ~sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Frame-level UART receive controller: start detect, 3-sample majority vote, word assembly
// and delivery. Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = DefDataBits,
    parameter int unsigned SMP_PER_BIT = DefSmpPerBit,
    parameter int unsigned PARITY_ODD  = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rxd,
    input  logic           sample_tick,
    output logic           rx_start,
    output logic           rx_done,
    output logic           busy,
    uart_rx_ctrl_if.master rx_if
);

    localparam int unsigned SW = $clog2(SMP_PER_BIT);
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SW-1:0] LastSmp = SW'(SMP_PER_BIT - 1);
    localparam logic [SW-1:0] Vote0   = SW'(vote_idx(SMP_PER_BIT, 0));
    localparam logic [SW-1:0] Vote1   = SW'(vote_idx(SMP_PER_BIT, 1));
    localparam logic [SW-1:0] Vote2   = SW'(vote_idx(SMP_PER_BIT, 2));
    localparam logic [BW-1:0] LastBit = BW'(DATA_BITS - 1);

    logic rxd_s, fall;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (rxd),
        .rxd_s (rxd_s),
        .fall  (fall)
    );

    rx_state_e            state_q, state_d;
    logic [SW-1:0]        smp_cnt_q, smp_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [2:0]           vote_q, vote_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_start_q, rx_start_d;
    logic                 rx_done_q, rx_done_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 voted, bit_end, parity_bad, load;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic perr_q, perr_d;
    assign parity_bad = par_q != (^data_q ^ (PARITY_ODD != 0));
`else
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD != 0;
    assign parity_bad        = 1'b0;
`endif

    assign voted   = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) | (vote_q[1] & vote_q[2]);
    assign bit_end = sample_tick && (smp_cnt_q == LastSmp);

    always_comb begin
        state_d    = state_q;
        smp_cnt_d  = smp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        vote_d     = vote_q;
        data_d     = data_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_start_d = 1'b0;
        rx_done_d  = 1'b0;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;
        load       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
        perr_d     = 1'b0;
`endif

        if (state_q != StIdle && sample_tick) begin
            smp_cnt_d = bit_end ? '0 : smp_cnt_q + 1'b1;
            if (smp_cnt_q == Vote0) vote_d[0] = rxd_s;
            if (smp_cnt_q == Vote1) vote_d[1] = rxd_s;
            if (smp_cnt_q == Vote2) vote_d[2] = rxd_s;
        end

        unique case (state_q)
            StIdle: begin
                smp_cnt_d = '0;
                bit_cnt_d = '0;
                if (fall) begin
                    rx_start_d = 1'b1;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    if (voted) begin
                        rx_done_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (bit_end) begin
                    data_d[bit_cnt_q] = voted;
                    if (bit_cnt_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    par_d   = voted;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    rx_done_d = 1'b1;
                    state_d   = StIdle;
                    if (!voted) begin
                        ferr_d = 1'b1;
                    end else if (parity_bad) begin
`ifdef UART_RX_PARITY_EN
                        perr_d = 1'b1;
`endif
                    end else if (!rx_valid_q || rx_if.rx_ready) begin
                        load = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A load in the same cycle as a consume keeps rx_valid high with the new word.
        if (load) begin
            rx_data_d  = data_q;
            rx_valid_d = 1'b1;
        end else if (rx_valid_q && rx_if.rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            smp_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            vote_q     <= '0;
            data_q     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_start_q <= 1'b0;
            rx_done_q  <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            smp_cnt_q  <= smp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            vote_q     <= vote_d;
            data_q     <= data_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_start_q <= rx_start_d;
            rx_done_q  <= rx_done_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign rx_start        = rx_start_q;
    assign rx_done         = rx_done_q;
    assign busy            = state_q != StIdle;
    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = ferr_q;
    assign rx_if.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = perr_q;
`else
    assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: acts as tick generator and serial source, counts output pulses.
module tb_uart_rx_ctrl;

`ifdef UART_RX_PARITY_EN
    localparam int FrameTicks = 99;
`else
    localparam int FrameTicks = 90;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    logic sample_tick = 1'b0;
    logic rx_start, rx_done, busy;

    uart_rx_ctrl_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_ctrl #(
        .DATA_BITS   (8),
        .SMP_PER_BIT (9),
        .PARITY_ODD  (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd         (rxd),
        .sample_tick (sample_tick),
        .rx_start    (rx_start),
        .rx_done     (rx_done),
        .busy        (busy),
        .rx_if       (rx_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0, n_done = 0, n_ferr = 0, n_perr = 0, n_ovr = 0;
    int tick_cnt = 0, done_ticks = 0;

    // Outputs are stable across the rising edge, so each one-cycle pulse is counted once.
    always @(posedge clk) begin
        if (rx_start) begin
            n_start  = n_start + 1;
            tick_cnt = 0;
        end
        if (sample_tick) tick_cnt = tick_cnt + 1;
        if (rx_done) begin
            n_done     = n_done + 1;
            done_ticks = tick_cnt;
        end
        if (rx_if.frame_err)  n_ferr = n_ferr + 1;
        if (rx_if.parity_err) n_perr = n_perr + 1;
        if (rx_if.overrun)    n_ovr  = n_ovr + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed no end of run, expected finish before 5ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one frame, one tick every 16 cycles; abort_at >= 0 stops before that tick.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input bit inv_mid, input bit glitch, input int abort_at);
        logic [10:0] bits;
        int          nticks;
        bit          seen;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
        bits[9]  = par;
        bits[10] = stop;
`else
        bits[9]  = stop;
        bits[10] = par | 1'b1;
`endif
        nticks = glitch ? 9 : FrameTicks;
        @(negedge clk) rxd = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rx_start) seen = 1'b1;
        end
        check("rx_start_seen", 32'(seen), 32'd1);
        if (!seen) begin
            rxd = 1'b1;
            return;
        end
        for (int t = 0; t < nticks; t++) begin
            int   b;
            int   s;
            logic v;
            if (t == abort_at) return;
            b = t / 9;
            s = t % 9;
            v = bits[b];
            if (inv_mid && b >= 1 && b <= 8 && s == 4) v = ~v;
            if (glitch) v = (s < 2) ? 1'b0 : 1'b1;
            rxd = v;
            repeat (15) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic consume();
        @(negedge clk) rx_if.rx_ready = 1'b1;
        @(negedge clk) rx_if.rx_ready = 1'b0;
        check("consume_clears_valid", 32'(rx_if.rx_valid), 32'd0);
    endtask

    int s_start, s_done, s_ferr, s_perr, s_ovr;

    task automatic snap();
        s_start = n_start;
        s_done  = n_done;
        s_ferr  = n_ferr;
        s_perr  = n_perr;
        s_ovr   = n_ovr;
    endtask

    initial begin
        rx_if.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl_flags", 32'({rx_start, rx_done, busy, rx_if.rx_valid,
                                       rx_if.frame_err, rx_if.parity_err, rx_if.overrun}), 32'd0);
        check("reset_rx_data", 32'(rx_if.rx_data), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: clean 0xA5 frame
        snap();
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        check("t1_start_pulses", 32'(n_start - s_start), 32'd1);
        check("t1_done_pulses", 32'(n_done - s_done), 32'd1);
        check("t1_ticks_start_to_done", 32'(done_ticks), 32'(FrameTicks));
        check("t1_valid", 32'(rx_if.rx_valid), 32'd1);
        check("t1_data", 32'(rx_if.rx_data), 32'hA5);
        check("t1_err_pulses", 32'((n_ferr - s_ferr) + (n_perr - s_perr) + (n_ovr - s_ovr)), 32'd0);
        check("t1_busy_idle", 32'(busy), 32'd0);
        consume();

        // 2: false start, low only for the first two samples
        snap();
        send_frame(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        check("t2_done_pulses", 32'(n_done - s_done), 32'd1);
        check("t2_ticks_to_done", 32'(done_ticks), 32'd9);
        check("t2_valid", 32'(rx_if.rx_valid), 32'd0);
        check("t2_frame_err", 32'(n_ferr - s_ferr), 32'd0);
        check("t2_overrun", 32'(n_ovr - s_ovr), 32'd0);
        check("t2_busy", 32'(busy), 32'd0);

        // 3: bad stop bit, then a good frame
        snap();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check("t3_frame_err", 32'(n_ferr - s_ferr), 32'd1);
        check("t3_valid_after_ferr", 32'(rx_if.rx_valid), 32'd0);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        check("t3_frame_err_once", 32'(n_ferr - s_ferr), 32'd1);
        check("t3_valid", 32'(rx_if.rx_valid), 32'd1);
        check("t3_data", 32'(rx_if.rx_data), 32'h55);
        consume();

        // 4: overrun with consumer stalled
        snap();
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        check("t4_first_data", 32'(rx_if.rx_data), 32'h11);
        check("t4_first_overrun", 32'(n_ovr - s_ovr), 32'd0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        check("t4_overrun", 32'(n_ovr - s_ovr), 32'd1);
        check("t4_data_held", 32'(rx_if.rx_data), 32'h11);
        check("t4_valid_held", 32'(rx_if.rx_valid), 32'd1);
        consume();

        // 5a: middle sample of every data bit corrupted
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        check("t5_vote_data", 32'(rx_if.rx_data), 32'h5A);
        check("t5_vote_valid", 32'(rx_if.rx_valid), 32'd1);

        // 5b: reset at tick 40 of a frame, with a word still pending
        snap();
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 40);
        check("t5_busy_before_reset", 32'(busy), 32'd1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("t5_reset_flags", 32'({rx_start, rx_done, busy, rx_if.rx_valid,
                                     rx_if.frame_err, rx_if.parity_err, rx_if.overrun}), 32'd0);
        check("t5_reset_data", 32'(rx_if.rx_data), 32'd0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("t5_no_done_after_reset", 32'(n_done - s_done), 32'd0);
        check("t5_no_flags_after_reset",
              32'((n_ferr - s_ferr) + (n_perr - s_perr) + (n_ovr - s_ovr)), 32'd0);

`ifdef UART_RX_PARITY_EN
        // 6: even parity; 0x07 needs parity bit 1
        snap();
        send_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        check("t6_parity_err", 32'(n_perr - s_perr), 32'd1);
        check("t6_ticks", 32'(done_ticks), 32'd99);
        check("t6_valid_after_perr", 32'(rx_if.rx_valid), 32'd0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        check("t6_parity_err_once", 32'(n_perr - s_perr), 32'd1);
        check("t6_valid", 32'(rx_if.rx_valid), 32'd1);
        check("t6_data", 32'(rx_if.rx_data), 32'h07);
`endif

        check("parity_err_idle", 32'(rx_if.parity_err), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Frame-level controller for the UART receive path. Synchronises the serial input and detects the start edge. Starts and stops the oversampling tick generator (9 ticks per bit) via rx_start/rx_done, majority-votes each bit and assembles the data word. Presents the received byte on a valid/ready interface, with frame, parity and overrun error flags.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first
SMP_PER_BIT, 9, sample ticks per bit; must be odd and at least 5
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; used only when parity is compiled in

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
rxd  input  1  raw serial line, asynchronous to clk, idles high
sample_tick  input  1  one-cycle pulse from tick generator, SMP_PER_BIT per bit period
rx_start  output  1  one-cycle pulse that starts the tick generator
rx_done  output  1  one-cycle pulse that stops the tick generator
rx_data  output  DATA_BITS  received word, held while rx_valid
rx_valid  output  1  rx_data holds an unconsumed word
rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready
frame_err  output  1  one-cycle pulse: stop bit voted 0
parity_err  output  1  one-cycle pulse: parity mismatch; constant 0 without the macro
overrun  output  1  one-cycle pulse: good frame dropped because the buffer was full
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; synchroniser flops 1; state IDLE; all counters 0.
- rxd passes through 2 flops to give rxd_s; rxd_q is rxd_s delayed one cycle.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: when rxd_q=1 and rxd_s=0, pulse rx_start and move to START. Clear smp_cnt and bit_cnt.
- smp_cnt counts sample_tick within a bit, 0..SMP_PER_BIT-1, and wraps to 0 on the last tick.
- Vote samples are at smp_cnt M-1, M and M+1, where M=SMP_PER_BIT/2 (3, 4, 5 by default). Each vote sample records rxd_s. Bit value = majority of the 3 vote samples.
- Bit ends on the tick where smp_cnt=SMP_PER_BIT-1.
- START at bit end:
  - vote 1: false start; pulse rx_done, go to IDLE, no other flags.
  - vote 0: go to DATA.
- DATA at each bit end: shift the voted bit into position bit_cnt (LSB first). After bit_cnt=DATA_BITS-1, go to PARITY (macro) or STOP.
- STOP at bit end: pulse rx_done and go to IDLE. Then:
  - vote 0: frame_err pulse; word discarded.
  - vote 1 and no parity error: deliver the word.
- Frame length is 10 bits (90 ticks) without parity, 11 bits (99 ticks) with it. rx_done comes 1 cycle after the final tick. rx_start comes 1 cycle after the edge is seen on rxd_s.
- Delivery rules:
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle: load rx_data and set rx_valid=1.
  - If rx_valid=1 and rx_ready=0: pulse overrun; rx_data unchanged; new word dropped.
- rx_valid clears on a rx_valid && rx_ready cycle when no new word loads in that cycle.
- Cycles without sample_tick never advance smp_cnt or the state (except the IDLE edge detect).
- After rx_done, IDLE needs a fresh high-to-low transition of rxd_s. A line held low never retriggers.
- Reset mid-frame: immediately return to the reset state; no rx_done or flag pulses.
- rx_start and rx_done never assert in the same cycle.

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined: a PARITY state follows DATA for one bit. Expected bit = XOR of data bits, XOR PARITY_ODD. On mismatch, parity_err pulses at the STOP bit end in place of delivery. frame_err has priority: if both errors occur, only frame_err pulses.
- Undefined: no PARITY state; parity_err tied to 0; PARITY_ODD unused.

Decomposition:
- Package uart_pkg: state enum type for the controller, default SMP_PER_BIT=9 and DATA_BITS=8 constants, and the vote-index function (mid-1, mid, mid+1).
- Sub-module uart_rx_sync: 2-flop synchroniser plus falling-edge detect. Outputs rxd_s and a fall pulse; its flops reset to 1.

Test Plan:
1. Tick every 16 cycles after rx_start; send 0xA5 with stop=1 -> exactly one rx_start and one rx_done pulse, 90 ticks apart; rx_valid=1; rx_data=8'hA5; no error flags.
2. rxd low only for smp_cnt 0-1 of the start bit, then high -> rx_done after 9 ticks; rx_valid, frame_err and overrun stay 0; busy returns to 0.
3. Send 0x3C with stop bit=0 -> frame_err pulses once; rx_valid stays 0. The next 0x55 frame decodes correctly.
4. rx_ready held 0; send 0x11 then 0x22 -> overrun pulses on the second frame; rx_data stays 8'h11. Then rx_ready=1 for one cycle -> rx_valid=0.
5. Send 0x5A with the sample at smp_cnt=4 inverted in every data bit -> rx_data=8'h5A. Separately, assert rst_n=0 at tick 40 of a frame -> all outputs 0 and no rx_done.
6. UART_RX_PARITY_EN defined, PARITY_ODD=0: send 0x07 with parity bit 0 -> parity_err pulses at tick 99 and no rx_valid. Resend with parity bit 1 -> rx_data=8'h07.
